fifo_rd_display: RTL
====================

# fifo_rd_display

Read-side consumer stage of the switch FIFO project. Clocked by the divided read clock, it pops one word at a time from the switch FIFO and holds each word on the LEDs for a programmable number of read-clock cycles. It runs continuously (run mode) or advances one word per push-button press (step mode), and keeps a running pop count for display.

## Interface
- `DATA_W`, default 8: FIFO word width and LED width.
- `HOLD_CYCLES`, default 4: number of cycles each word is held before the next pop may start. Must be ≥ 1.
- `CNT_W`, default 8: width of `pop_count`.

Ports:
- `clk_in` input, 1 bit: read clock, which is the divided clock; the only clock in the block.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `run` input, 1 bit: level input; 1 selects run mode and 0 selects step mode. Synchronous to `clk_in`.
- `step` input, 1 bit: step button level, debounced upstream. Its rising edge requests one pop.
- `clr` input, 1 bit: synchronous clear.
- `fifo_empty` input, 1 bit: FIFO empty flag.
- `fifo_rd_data` input, `DATA_W` bits: FIFO read data, valid one cycle after `fifo_rd_en`.
- `fifo_rd_en` output, 1 bit: one-cycle pop strobe.
- `led_out` output, `DATA_W` bits: last captured word.
- `led_valid` output, 1 bit: high once any word has been captured.
- `pop_count` output, `CNT_W` bits: number of words captured, modulo 2^`CNT_W`.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- **States:** IDLE, POP, LATCH, HOLD. Encoding is binary, 2 bits.
- **IDLE:**
  - Moves to POP when `!fifo_empty` and either `run`=1 or `step_pend`=1.
  - Otherwise stays in IDLE.
- **POP:**
  - `fifo_rd_en` = (state==POP) && `!fifo_empty`.
  - If `fifo_empty`=1, returns to IDLE with no pop and `step_pend` unchanged.
  - Otherwise goes to LATCH and clears `step_pend`.
- **LATCH:**
  - `led_out` <= `fifo_rd_data`.
  - `led_valid` <= 1.
  - `pop_count` <= `pop_count`+1, wrapping from 2^`CNT_W`−1 to 0.
  - `hold_cnt` <= `HOLD_CYCLES`−1.
  - Goes to HOLD.
- **HOLD:**
  - Decrements `hold_cnt`.
  - Goes to IDLE in the cycle where `hold_cnt`==0.
  - `hold_cnt` width is clog2(`HOLD_CYCLES`+1).
- **Step edge detect:**
  - `step_q` registers `step`; a rise is `step` & `!step_q`.
  - A rise sets `step_pend`. The request is one deep: extra rises while pending are dropped.
  - A rise while busy is kept, so exactly one more word is popped after the current hold.
  - `run`=1 clears `step_pend` every cycle.
- **Clear (`clr`=1):**
  - Next state is IDLE.
  - `led_out`=0, `led_valid`=0, `pop_count`=0, `step_pend`=0, `hold_cnt`=0.
  - If `clr` arrives in POP, the strobe already issued is not retracted. The popped word is discarded and LATCH is not entered.
  - `clr` has priority over every other transition.
- **Reset (`reset_n`=0):** same values as clear, plus `step_q`=0. Takes effect immediately, including mid-hold.

## Timing
- **Outputs:**
  - Registered: all outputs except `fifo_rd_en`.
  - Combinational decode of state plus `fifo_empty`: `fifo_rd_en` only.
- **Reset values of outputs:** `fifo_rd_en`=0, `led_out`=0, `led_valid`=0, `pop_count`=0, `busy`=0.
- **Per-word sequence:**
  - Cycle N: IDLE, condition true.
  - N+1: POP, with `fifo_rd_en`=1.
  - N+2: LATCH, with data on `fifo_rd_data`.
  - N+3: `led_out` updated.
  - N+3 to N+2+`HOLD_CYCLES`: HOLD.
  - Next IDLE at N+3+`HOLD_CYCLES`.
- **Continuous run throughput:** one word per 3+`HOLD_CYCLES` cycles, i.e. 7 cycles at the defaults.
- **Step latency:** a rise sampled at cycle S gives `step_pend`=1 at S+1, so `fifo_rd_en` at S+2 at the earliest.
- **`fifo_rd_en` pulse width:** never high for two consecutive cycles; at most one pop in flight.

## Structure
- **Shared package `fifo_pkg`:**
  - state enum or localparams: `ST_IDLE`=0, `ST_POP`=1, `ST_LATCH`=2, `ST_HOLD`=3.
  - the shared default `DATA_W`.
- **One sub-module, `rise_detect`:** one flop plus an AND gate; produces the step pulse and is reusable for other buttons.
- **FSM, hold counter and pop counter:** stay in this module.

## Test plan
- Reset, then push 0xA5, 0x3C with `run`=1 and `HOLD_CYCLES`=4 → `fifo_rd_en` pulses 7 cycles apart. `led_out`=0xA5, then 0x3C; `pop_count` 1, then 2; `led_valid` rises with the first capture.
- `run`=0 with 3 words queued and two `step` rises 10 cycles apart → exactly 2 pops, `pop_count`=2, one word left in the FIFO.
- `run`=0, `step` rises twice during a HOLD → exactly one additional pop after HOLD ends.
- Preload `pop_count` via 255 pops, then 1 more → `pop_count` wraps to 0; `led_out` equals the 256th word.
- `clr` asserted in the POP cycle → next state IDLE; `led_out`=0, `led_valid`=0, `pop_count`=0. The popped word is not displayed and the FIFO has one fewer word.
- `reset_n` dropped mid-HOLD with `led_out`=0x3C → all outputs 0 immediately, without waiting for a clock edge; after release, with `fifo_empty`=1, no `fifo_rd_en` is issued.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the switch FIFO project.
// Read-side FSM state encoding lives here so other stages can decode it.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_LATCH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge pulse generator for an already-debounced level input.
// One flop plus an AND gate; reusable for any push-button.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/fifo_rd_display.sv
// Read-side consumer: pops one FIFO word at a time and holds it on
// the LEDs, in free-running or single-step mode, counting pops.
module fifo_rd_display
  import fifo_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              run,
  input  logic              step,
  input  logic              clr,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] led_out,
  output logic              led_valid,
  output logic [CNT_W-1:0]  pop_count,
  output logic              busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  state_t            r_state;
  logic              r_pend;
  logic [HW-1:0]     r_hold;
  logic [DATA_W-1:0] r_led;
  logic              r_vld;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              w_rise;

  rise_detect u_step_rise (
    .i_clk   (clk_in),
    .i_rst_n (reset_n),
    .i_d     (step),
    .o_rise  (w_rise)
  );

  assign fifo_rd_en = (r_state == ST_POP) && !fifo_empty;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
      r_hold  <= '0;
      r_led   <= '0;
      r_vld   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
      r_hold  <= '0;
      r_led   <= '0;
      r_vld   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      // a new rise beats the consume, so a press during a pop is kept
      if (run) begin
        r_pend <= 1'b0;
      end else if (w_rise) begin
        r_pend <= 1'b1;
      end else if (fifo_rd_en) begin
        r_pend <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (!fifo_empty && (run || r_pend)) begin
            r_state <= ST_POP;
            r_busy  <= 1'b1;
          end
        end
        ST_POP: begin
          if (fifo_empty) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          r_led   <= fifo_rd_data;
          r_vld   <= 1'b1;
          r_cnt   <= r_cnt + 1'b1;
          r_hold  <= HW'(HOLD_CYCLES - 1);
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_hold == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign led_out   = r_led;
  assign led_valid = r_vld;
  assign pop_count = r_cnt;
  assign busy      = r_busy;

endmodule
